// File: rtl/uart_rx_packetizer_if.sv
// uart_rx_packetizer_if: byte-receiver input, packet handshake, buffer read and error status
interface uart_rx_packetizer_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       pkt_ready;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic       err_pulse;
  logic [1:0] err_code;
  modport master (
    output rx_done, rx_data, pkt_ready, rd_addr,
    input  rd_data, pkt_valid, pkt_len, err_pulse, err_code
  );
  modport slave (
    input  rx_done, rx_data, pkt_ready, rd_addr,
    output rd_data, pkt_valid, pkt_len, err_pulse, err_code
  );
endinterface

// File: rtl/uart_rx_packetizer.sv
// uart_rx_packetizer: frames SYNC/LEN/PAYLOAD/XOR-CSUM byte streams into a held, readable packet
module uart_rx_packetizer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 25000
) (
  input logic clk,
  input logic rst_n,
  uart_rx_packetizer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, LEN = 3'd1, PAYLOAD = 3'd2, CSUM = 3'd3, HOLD = 3'd4;
  logic [2:0]  state;
  logic [4:0]  len;
  logic [4:0]  pkt_len_q;
  logic [3:0]  idx;
  logic [7:0]  csum;
  logic [15:0] cnt;
  logic [7:0]  buf_q [16];
  logic        err_pulse_q;
  logic [1:0]  err_code_q;
  logic        timed, tmo, bad_len, err_set;
  logic [1:0]  err_nxt;
  always_comb begin
    timed   = state == LEN || state == PAYLOAD || state == CSUM;
    // the counter value T-2 means this edge would make it T-1: fire now unless a byte arrives
    tmo     = timed && !bus.rx_done && cnt == 16'(TIMEOUT_CYC - 2);
    bad_len = bus.rx_data == 8'h00 || bus.rx_data > 8'(MAX_LEN);
    err_set = tmo || (bus.rx_done && ((state == LEN && bad_len) ||
              (state == CSUM && bus.rx_data != csum) || state == HOLD));
    err_nxt = tmo ? 2'd0 : state == LEN ? 2'd1 : state == CSUM ? 2'd2 : 2'd3;
  end
  assign bus.rd_data   = {1'b0, bus.rd_addr} < pkt_len_q ? buf_q[bus.rd_addr] : 8'h00;
  assign bus.pkt_valid = state == HOLD;
  assign bus.pkt_len   = pkt_len_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len         <= '0;
      pkt_len_q   <= '0;
      idx         <= '0;
      csum        <= '0;
      cnt         <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      err_pulse_q <= err_set;
      if (err_set) err_code_q <= err_nxt;
      cnt <= (timed && !bus.rx_done && !tmo) ? cnt + 16'd1 : 16'd0;
      if (tmo) state <= IDLE;
      else if (state == HOLD) begin
        if (bus.pkt_ready) state <= IDLE;
      end else if (bus.rx_done) begin
        case (state)
          IDLE: if (bus.rx_data == SYNC_BYTE) state <= LEN;
          LEN:
            if (bad_len) state <= IDLE;
            else begin
              len   <= bus.rx_data[4:0];
              csum  <= bus.rx_data;
              idx   <= '0;
              state <= PAYLOAD;
            end
          PAYLOAD: begin
            buf_q[idx] <= bus.rx_data;
            csum       <= csum ^ bus.rx_data;
            idx        <= idx + 4'd1;
            if ({1'b0, idx} == len - 5'd1) state <= CSUM;
          end
          CSUM:
            if (bus.rx_data == csum) begin
              pkt_len_q <= len;
              state     <= HOLD;
            end else state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_packetizer.sv
// tb_uart_rx_packetizer: directed scenarios plus randomized frames checked against frame-level expectations
module tb_uart_rx_packetizer;
  localparam int T = 40;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int failures = 0;
  logic [4:0] last_len = 0;
  uart_rx_packetizer_if bus();
  uart_rx_packetizer #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_done = 1; bus.rx_data = b;
    tick();
    bus.rx_done = 0;
  endtask
  task automatic chk_err(input string name, input logic [1:0] code);
    checks++;
    if (bus.err_pulse !== 1'b1 || bus.err_code !== code) begin
      failures++;
      $display("FAIL %s err_pulse=%b err_code=%0d expected pulse=1 code=%0d", name, bus.err_pulse, bus.err_code, code);
    end
    tick();
    checks++;
    if (bus.err_pulse !== 1'b0) begin
      failures++;
      $display("FAIL %s_single err_pulse=%b expected 0", name, bus.err_pulse);
    end
  endtask
  task automatic chk_valid(input string name, input logic v, input logic [4:0] l);
    checks++;
    if (bus.pkt_valid !== v || bus.pkt_len !== l) begin
      failures++;
      $display("FAIL %s pkt_valid=%b pkt_len=%0d expected valid=%b len=%0d", name, bus.pkt_valid, bus.pkt_len, v, l);
    end
  endtask
  task automatic chk_rd(input string name, input logic [3:0] a, input logic [7:0] e);
    bus.rd_addr = a; #1;
    checks++;
    if (bus.rd_data !== e) begin
      failures++;
      $display("FAIL %s rd_data[%0d]=%h expected %h", name, a, bus.rd_data, e);
    end
  endtask
  task automatic handshake(input string name);
    bus.pkt_ready = 1;
    tick();
    bus.pkt_ready = 0;
    checks++;
    if (bus.pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s pkt_valid=%b expected 0 after pkt_ready", name, bus.pkt_valid);
    end
  endtask
  task automatic test_reset();
    chk_valid("reset_pkt", 1'b0, 5'd0);
    checks++;
    if (bus.err_pulse !== 1'b0 || bus.err_code !== 2'd0) begin
      failures++;
      $display("FAIL reset_err err_pulse=%b err_code=%0d expected 0/0", bus.err_pulse, bus.err_code);
    end
    chk_rd("reset_rd", 4'd0, 8'h00);
    tick();
  endtask
  task automatic test_basic();
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
    chk_valid("basic_pre", 1'b0, 5'd0);
    send(8'h31);
    chk_valid("basic_valid", 1'b1, 5'd2);
    chk_rd("basic", 4'd0, 8'h11);
    chk_rd("basic", 4'd1, 8'h22);
    chk_rd("basic", 4'd2, 8'h00);
    handshake("basic_hs");
    last_len = 2;
  endtask
  task automatic test_bad_len();
    send(8'hA5); send(8'h00);
    chk_err("bad_len_zero", 2'd1);
    send(8'hA5); send(8'h11);
    chk_err("bad_len_17", 2'd1);
    chk_valid("bad_len_pkt", 1'b0, last_len);
  endtask
  task automatic test_csum();
    send(8'hA5); send(8'h01); send(8'h55); send(8'h00);
    chk_err("csum_bad", 2'd2);
    chk_valid("csum_bad_pkt", 1'b0, last_len);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h54);
    chk_valid("csum_good", 1'b1, 5'd1);
    chk_rd("csum_good", 4'd0, 8'h55);
    handshake("csum_hs");
    last_len = 1;
  endtask
  task automatic test_timeout();
    int n = 0;
    send(8'hA5); send(8'h03);
    while (bus.err_pulse !== 1'b1 && n < 4 * T) begin
      tick(); n++;
    end
    checks++;
    if (n != T - 1) begin
      failures++;
      $display("FAIL timeout_latency cycles=%0d expected %0d", n, T - 1);
    end
    chk_err("timeout_code", 2'd0);
    send(8'h7E);
    checks++;
    if (bus.err_pulse !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle err_pulse=%b expected 0", bus.err_pulse);
    end
  endtask
  task automatic test_timeout_boundary();
    send(8'hA5); send(8'h01);
    idle(T - 2);
    send(8'h10);
    checks++;
    if (bus.err_pulse !== 1'b0) begin
      failures++;
      $display("FAIL tmo_edge_byte err_pulse=%b expected 0", bus.err_pulse);
    end
    idle(T - 2);
    send(8'h11);
    chk_valid("tmo_edge_pkt", 1'b1, 5'd1);
    chk_rd("tmo_edge", 4'd0, 8'h10);
    handshake("tmo_edge_hs");
    last_len = 1;
  endtask
  task automatic test_overrun();
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h31);
    last_len = 2;
    idle(2);
    chk_valid("ovr_hold", 1'b1, 5'd2);
    send(8'h77);
    chk_valid("ovr_still", 1'b1, 5'd2);
    chk_rd("ovr", 4'd0, 8'h11);
    chk_rd("ovr", 4'd1, 8'h22);
    bus.rd_addr = 0;
    checks++;
    if (bus.err_pulse !== 1'b1 || bus.err_code !== 2'd3) begin
      failures++;
      $display("FAIL ovr_err err_pulse=%b err_code=%0d expected 1/3", bus.err_pulse, bus.err_code);
    end
    tick();
    bus.pkt_ready = 1; bus.rx_done = 1; bus.rx_data = 8'h88;
    tick();
    bus.pkt_ready = 0; bus.rx_done = 0;
    chk_valid("ovr_hs_drop", 1'b0, 5'd2);
    chk_err("ovr_hs_err", 2'd3);
  endtask
  task automatic test_reset_mid();
    send(8'hA5); send(8'h02); send(8'h11);
    rst_n = 0; #2;
    chk_valid("rstmid_pkt", 1'b0, 5'd0);
    checks++;
    if (bus.err_pulse !== 1'b0 || bus.err_code !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_err err_pulse=%b err_code=%0d expected 0/0", bus.err_pulse, bus.err_code);
    end
    chk_rd("rstmid", 4'd0, 8'h00);
    bus.rd_addr = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    last_len = 0;
    send(8'hA5); send(8'h01); send(8'hAA); send(8'hAB);
    chk_valid("rstmid_pkt2", 1'b1, 5'd1);
    chk_rd("rstmid2", 4'd0, 8'hAA);
    handshake("rstmid_hs");
    last_len = 1;
  endtask
  task automatic test_random();
    for (int f = 0; f < 30; f++) begin
      int kind = $urandom_range(0, 2);
      int nz = $urandom_range(0, 3);
      logic [7:0] pay [$];
      logic [7:0] cs, b, l;
      for (int k = 0; k < nz; k++) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
        idle($urandom_range(0, 3));
        send(b);
        checks++;
        if (bus.err_pulse !== 1'b0) begin
          failures++;
          $display("FAIL rnd_noise frame %0d err_pulse=%b expected 0", f, bus.err_pulse);
        end
      end
      idle($urandom_range(0, 3));
      send(8'hA5);
      if (kind == 2) begin
        l = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
        idle($urandom_range(0, 3));
        send(l);
        chk_err("rnd_len", 2'd1);
        chk_valid("rnd_len_pkt", 1'b0, last_len);
        continue;
      end
      l = 8'($urandom_range(1, 16));
      cs = l;
      for (int k = 0; k < int'(l); k++) begin
        b = 8'($urandom_range(0, 255));
        pay.push_back(b);
        cs ^= b;
      end
      if (kind == 1) cs ^= 8'($urandom_range(1, 255));
      idle($urandom_range(0, 3));
      send(l);
      foreach (pay[k]) begin
        idle($urandom_range(0, 3));
        send(pay[k]);
      end
      chk_valid("rnd_pre", 1'b0, last_len);
      idle($urandom_range(0, 3));
      send(cs);
      if (kind == 1) begin
        chk_err("rnd_csum", 2'd2);
        chk_valid("rnd_csum_pkt", 1'b0, last_len);
      end else begin
        last_len = l[4:0];
        chk_valid("rnd_pkt", 1'b1, last_len);
        for (int k = 0; k < 16; k++) chk_rd("rnd", 4'(k), k < int'(l) ? pay[k] : 8'h00);
        bus.rd_addr = 0;
        tick();
        handshake("rnd_hs");
      end
    end
  endtask
  initial begin
    bus.rx_done = 0; bus.rx_data = 0; bus.pkt_ready = 0; bus.rd_addr = 0;
    idle(3);
    test_reset();
    rst_n = 1;
    tick();
    test_reset();
    test_basic();
    test_bad_len();
    test_csum();
    test_timeout();
    test_timeout_boundary();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
